// File: rtl/cpu_pkg.sv
// Shared definitions for the 12-bit CPU: opcodes, sequencer states and
// instruction field positions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_INC_SR   = 4'h1;
  localparam logic [3:0] OP_NAND_SR  = 4'h2;
  localparam logic [3:0] OP_SRA_SR   = 4'h3;
  localparam logic [3:0] OP_XOR_SR   = 4'h4;
  localparam logic [3:0] OP_INC_BIO  = 4'h5;
  localparam logic [3:0] OP_NAND_BIO = 4'h6;
  localparam logic [3:0] OP_SRA_BIO  = 4'h7;
  localparam logic [3:0] OP_XOR_BIO  = 4'h8;
  localparam logic [3:0] OP_LDI      = 4'h9;
  localparam logic [3:0] OP_LDSR     = 4'hA;
  localparam logic [3:0] OP_JMP      = 4'hB;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam int OPC_HI = 11;
  localparam int OPC_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode classifier used by the control unit.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_bio,
  output logic       is_ldi,
  output logic       is_ldsr,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    is_alu  = 1'b0;
    is_bio  = 1'b0;
    is_ldi  = 1'b0;
    is_ldsr = 1'b0;
    is_jmp  = 1'b0;
    is_halt = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_INC_SR, OP_NAND_SR, OP_SRA_SR, OP_XOR_SR: is_alu = 1'b1;
      OP_INC_BIO, OP_NAND_BIO, OP_SRA_BIO, OP_XOR_BIO: begin
        is_alu = 1'b1;
        is_bio = 1'b1;
      end
      OP_LDI:  is_ldi  = 1'b1;
      OP_LDSR: is_ldsr = 1'b1;
      OP_JMP:  is_jmp  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer: fetches over req/ack, drives the
// external ALU and writes results back to acc or the BIO output latch.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] bio_in,
  output logic [DATA_W-1:0] bio_out,
  output logic              bio_oe,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal_op
);

  state_e            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] bio_lat;

  logic [3:0]       ir_op;
  logic [IMM_W-1:0] ir_imm;
  logic             is_alu, is_bio, is_ldi, is_ldsr, is_jmp, is_halt, illegal;
  logic             in_op;

  assign ir_op  = ir[OPC_HI:OPC_LO];
  assign ir_imm = ir[IMM_HI:IMM_LO];

  cpu_decoder u_dec (
    .opcode  (ir_op),
    .is_alu  (is_alu),
    .is_bio  (is_bio),
    .is_ldi  (is_ldi),
    .is_ldsr (is_ldsr),
    .is_jmp  (is_jmp),
    .is_halt (is_halt),
    .illegal (illegal)
  );

  // ALU controls are decoded from the registered ir/state so nothing on the
  // inputs reaches an output combinationally; outside DECODE/EXEC they idle.
  assign in_op      = (state == ST_DECODE) || (state == ST_EXEC);
  assign alu_opcode = (in_op && is_alu) ? ir_op : OP_NOP;
  assign alu_data1  = acc;
  assign alu_data2  = (in_op && is_bio) ? bio_lat : sr;
  assign imem_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= '0;
      acc        <= '0;
      sr         <= '0;
      ir         <= '0;
      bio_lat    <= '0;
      bio_out    <= '0;
      bio_oe     <= 1'b0;
      imem_req   <= 1'b0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            pc       <= pc + ADDR_W'(1);
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_bio) bio_lat <= bio_in;
          illegal_op <= illegal;
          state      <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_alu && !is_bio) acc <= alu_result;
          if (is_alu && is_bio) begin
            bio_out <= alu_result;
            bio_oe  <= 1'b1;
          end
          if (is_ldi)  acc <= DATA_W'(ir_imm);
          if (is_ldsr) sr  <= acc;
          if (is_jmp)  pc  <= ADDR_W'(ir_imm);
          if (is_halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_HALT: ;
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
